// File: rtl/opb_sim2ppc_pkg.sv
// Shared definitions for the OPB sim-to-PPC capture slave: register word offsets,
// STATUS bit positions and the register-select enum produced by the address decoder.
package opb_sim2ppc_pkg;

    // Word offsets (OPB_ABus[24:29]) within the 256-byte window
    localparam logic [5:0] OffData   = 6'h00;
    localparam logic [5:0] OffStatus = 6'h01;
    localparam logic [5:0] OffCount  = 6'h02;

    // STATUS bits counted from the LSB; these are OPB (big-endian) bits 31 and 30
    localparam int unsigned StatusNewBit = 0;
    localparam int unsigned StatusOvfBit = 1;

    typedef enum logic [1:0] {
        SelNone,
        SelData,
        SelStatus,
        SelCount
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [5:0] off);
        reg_sel_e sel;
        sel = SelNone;
        if (off == OffData) begin
            sel = SelData;
        end else if (off == OffStatus) begin
            sel = SelStatus;
        end else if (off == OffCount) begin
            sel = SelCount;
        end
        return sel;
    endfunction

endpackage

// File: rtl/opb_slave_ack.sv
// OPB slave front end: window decode, one-cycle registered acknowledge and the
// back-to-back guard that keeps a held select from acking in the cycle after an ack.
module opb_slave_ack
    import opb_sim2ppc_pkg::*;
#(
    parameter logic [31:0] BaseAddr = 32'h01100400,
    parameter logic [31:0] HighAddr = 32'h011004FF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        select_i,
    input  logic [31:0] addr_i,
    output logic        ack_o,
    output logic        accept_o,
    output reg_sel_e    sel_o
);

    logic hit;
    logic ack_d;
    logic ack_q;

    // Decode the window and accept a hit only while no ack is on the bus
    always_comb begin
        hit      = select_i && (addr_i >= BaseAddr) && (addr_i <= HighAddr);
        accept_o = hit && !ack_q;
        ack_d    = accept_o;
        sel_o    = decode_offset(addr_i[7:2]);
    end

    // Ack register; reset aborts any pending transfer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

    assign ack_o = ack_q;

endmodule

// File: rtl/opb_sim2ppc_capture.sv
// OPB slave publishing a fabric value to the PPC: DATA (RO), STATUS (NEW, sticky OVF)
// and, when SIM2PPC_COUNT_EN is defined, a 32-bit strobe COUNT at offset 0x08.
module opb_sim2ppc_capture
    import opb_sim2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01100400,
    parameter logic [31:0] C_HIGHADDR   = 32'h011004FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    input  logic [31:0] user_data_in,
    input  logic        user_valid,
    output logic        user_rd_pulse
);

    logic     accept;
    reg_sel_e sel;
    logic     rd_data;
    logic     wr_status;
    logic     ovf_clr;
    logic     ovf_set;
    logic [31:0] status_w;
    logic [31:0] rdata;

    logic [31:0] data_d, data_q;
    logic        new_d, new_q;
    logic        ovf_d, ovf_q;
    logic [31:0] dbus_d, dbus_q;
    logic        rd_pulse_d, rd_pulse_q;

    opb_slave_ack #(
        .BaseAddr (C_BASEADDR),
        .HighAddr (C_HIGHADDR)
    ) u_ack (
        .clk_i    (OPB_Clk),
        .rst_i    (OPB_Rst),
        .select_i (OPB_select),
        .addr_i   (OPB_ABus),
        .ack_o    (Sl_xferAck),
        .accept_o (accept),
        .sel_o    (sel)
    );

`ifdef SIM2PPC_COUNT_EN
    logic [31:0] count_d, count_q;
    logic        wr_count;
`endif

    // Register next-state and read mux; capture beats a DATA read, OVF set beats clear
    always_comb begin
        rd_data   = accept && OPB_RNW && (sel == SelData);
        wr_status = accept && !OPB_RNW && (sel == SelStatus);
        ovf_clr   = wr_status && OPB_BE[3] && OPB_DBus[30];
        ovf_set   = user_valid && new_q && !rd_data;

        data_d = user_valid ? user_data_in : data_q;

        new_d = new_q;
        if (rd_data) begin
            new_d = 1'b0;
        end
        if (user_valid) begin
            new_d = 1'b1;
        end

        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end

        status_w               = '0;
        status_w[StatusNewBit] = new_q;
        status_w[StatusOvfBit] = ovf_q;

`ifdef SIM2PPC_COUNT_EN
        wr_count = accept && !OPB_RNW && (sel == SelCount);
        count_d  = count_q;
        if (wr_count) begin
            count_d = '0;
        end
        if (user_valid) begin
            count_d = count_d + 32'd1;
        end
`endif

        rdata = '0;
        unique case (sel)
            SelData:   rdata = data_q;
            SelStatus: rdata = status_w;
`ifdef SIM2PPC_COUNT_EN
            SelCount:  rdata = count_q;
`else
            SelCount:  rdata = '0;
`endif
            SelNone:   rdata = '0;
        endcase

        // Read data rides with the ack only, so the OR-ed bus stays clean otherwise
        dbus_d     = (accept && OPB_RNW) ? rdata : '0;
        rd_pulse_d = rd_data;
    end

    // State registers with synchronous reset; strobes during reset are dropped
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_q     <= '0;
            new_q      <= 1'b0;
            ovf_q      <= 1'b0;
            dbus_q     <= '0;
            rd_pulse_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            new_q      <= new_d;
            ovf_q      <= ovf_d;
            dbus_q     <= dbus_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

`ifdef SIM2PPC_COUNT_EN
    // Strobe counter, wraps naturally at 32 bits
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

    assign Sl_DBus       = dbus_q;
    assign user_rd_pulse = rd_pulse_q;
    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29], OPB_DBus[31],
                         (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32), (C_FAMILY == "")};

endmodule

// File: tb/tb_opb_sim2ppc_capture.sv
// Directed bench for opb_sim2ppc_capture; the COUNT steps run only when
// SIM2PPC_COUNT_EN is defined, otherwise offset 0x08 is expected to read 0.
module tb_opb_sim2ppc_capture;

    localparam logic [31:0] Base = 32'h01100400;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] wdbus;
    logic        rnw;
    logic        sel;
    logic        seqaddr;
    logic [0:31] sl_dbus;
    logic        sl_ack;
    logic        sl_err;
    logic        sl_retry;
    logic        sl_tout;
    logic [31:0] udata;
    logic        uvalid;
    logic        urd;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    opb_sim2ppc_capture dut (
        .OPB_Clk       (clk),
        .OPB_Rst       (rst),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (wdbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel),
        .OPB_seqAddr   (seqaddr),
        .Sl_DBus       (sl_dbus),
        .Sl_xferAck    (sl_ack),
        .Sl_errAck     (sl_err),
        .Sl_retry      (sl_retry),
        .Sl_toutSup    (sl_tout),
        .user_data_in  (udata),
        .user_valid    (uvalid),
        .user_rd_pulse (urd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer: request cycle (optionally with a strobe), sample at T+1, one idle cycle
    task automatic xfer(input logic r, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ben, input logic strobe, input logic [31:0] sdata,
                        output logic [31:0] rd, output logic ack, output logic pulse,
                        output logic ack_next);
        sel    = 1'b1;
        rnw    = r;
        abus   = addr;
        wdbus  = wd;
        be     = ben;
        uvalid = strobe;
        udata  = sdata;
        tick();
        ack    = sl_ack;
        rd     = sl_dbus;
        pulse  = urd;
        sel    = 1'b0;
        uvalid = 1'b0;
        abus   = '0;
        wdbus  = '0;
        tick();
        ack_next = sl_ack;
    endtask

    task automatic strobe(input logic [31:0] d);
        uvalid = 1'b1;
        udata  = d;
        tick();
        uvalid = 1'b0;
    endtask

    logic [31:0] rd;
    logic        ack;
    logic        pulse;
    logic        ackn;
    int          acks;

    initial begin
        rst = 1'b1; abus = '0; be = '0; wdbus = '0; rnw = 1'b1; sel = 1'b0;
        seqaddr = 1'b0; udata = '0; uvalid = 1'b0;
        tick(); tick(); tick();
        check("rst_ack", {31'd0, sl_ack}, 32'd0);
        check("rst_dbus", sl_dbus, 32'd0);
        check("rst_rdpulse", {31'd0, urd}, 32'd0);
        rst = 1'b0;
        tick();

        // Read after reset
        xfer(1'b1, Base + 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("rd0_ack", {31'd0, ack}, 32'd1);
        check("rd0_data", rd, 32'd0);
        check("rd0_single_ack", {31'd0, ackn}, 32'd0);
        check("rd0_after_dbus", sl_dbus, 32'd0);
        xfer(1'b1, Base + 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("st0", rd, 32'd0);

        // Basic capture
        strobe(32'hDEADBEEF);
        xfer(1'b1, Base + 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("cap_status", rd, 32'h1);
        xfer(1'b1, Base + 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("cap_data", rd, 32'hDEADBEEF);
        check("cap_rdpulse", {31'd0, pulse}, 32'd1);
        check("cap_rdpulse_one", {31'd0, urd}, 32'd0);
        xfer(1'b1, Base + 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("cap_status_clr", rd, 32'h0);
        check("st_read_nopulse", {31'd0, pulse}, 32'd0);

        // Overflow, ignored writes, BE-gated clear
        strobe(32'h1);
        strobe(32'h2);
        xfer(1'b1, Base + 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("ovf_status", rd, 32'h3);
        xfer(1'b0, Base + 32'h0, 32'h1234, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("wr_data_ack", {31'd0, ack}, 32'd1);
        check("wr_dbus_zero", rd, 32'd0);
        xfer(1'b0, Base + 32'h4, 32'h2, 4'b1110, 1'b0, 32'h0, rd, ack, pulse, ackn);
        xfer(1'b1, Base + 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("ovf_be_gated", rd, 32'h3);
        xfer(1'b0, Base + 32'h4, 32'h2, 4'b0001, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("ovf_clr_ack", {31'd0, ack}, 32'd1);
        xfer(1'b1, Base + 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("ovf_cleared", rd, 32'h1);
        xfer(1'b1, Base + 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("ovf_data_last", rd, 32'h2);

        // Collision: DATA read acked at the same edge as a strobe
        strobe(32'hAA);
        xfer(1'b1, Base + 32'h0, 32'h0, 4'hF, 1'b1, 32'h55, rd, ack, pulse, ackn);
        check("col_old_data", rd, 32'hAA);
        check("col_rdpulse", {31'd0, pulse}, 32'd1);
        xfer(1'b1, Base + 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("col_new_kept", rd, 32'h1);
        xfer(1'b1, Base + 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("col_next_data", rd, 32'h55);

        // OVF clear write colliding with a fresh overflow: set wins
        strobe(32'h10);
        xfer(1'b0, Base + 32'h4, 32'h2, 4'b0001, 1'b1, 32'h11, rd, ack, pulse, ackn);
        xfer(1'b1, Base + 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("ovf_set_wins", rd, 32'h3);
        xfer(1'b0, Base + 32'h4, 32'h2, 4'b0001, 1'b0, 32'h0, rd, ack, pulse, ackn);
        xfer(1'b1, Base + 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("sw_data", rd, 32'h11);
        xfer(1'b1, Base + 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("sw_status", rd, 32'h0);

        // Select held through the ack cycle: only one ack
        strobe(32'h7);
        sel = 1'b1; rnw = 1'b1; abus = Base + 32'h4;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sl_ack) acks++;
            if (i == 1) begin
                check("hold_dbus_idle", sl_dbus, 32'd0);
                sel = 1'b0;
            end
        end
        check("hold_one_ack", acks, 32'd1);

        // Window boundaries
        xfer(1'b1, Base + 32'h100, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("oor_high_noack", {31'd0, ack}, 32'd0);
        check("oor_high_dbus", rd, 32'd0);
        xfer(1'b1, Base - 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("oor_low_noack", {31'd0, ack}, 32'd0);
        xfer(1'b1, Base + 32'hFC, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("top_word_ack", {31'd0, ack}, 32'd1);
        check("top_word_zero", rd, 32'd0);

        // Reset arriving with a request; strobe during reset dropped
        sel = 1'b1; rnw = 1'b1; abus = Base + 32'h4; rst = 1'b1;
        uvalid = 1'b1; udata = 32'h77;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (sl_ack) acks++;
        end
        check("rst_abort_noack", acks, 32'd0);
        sel = 1'b0; uvalid = 1'b0; rst = 1'b0;
        tick();
        check("rst_abort_idle", {31'd0, sl_ack}, 32'd0);
        xfer(1'b1, Base + 32'h4, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("rst_status", rd, 32'h0);
        xfer(1'b1, Base + 32'h0, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("rst_data", rd, 32'h0);

`ifdef SIM2PPC_COUNT_EN
        for (int i = 0; i < 5; i++) strobe(32'h100 + i);
        xfer(1'b1, Base + 32'h8, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("count5", rd, 32'd5);
        xfer(1'b0, Base + 32'h8, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        xfer(1'b1, Base + 32'h8, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("count_clr", rd, 32'd0);
        xfer(1'b0, Base + 32'h8, 32'h0, 4'hF, 1'b1, 32'h9, rd, ack, pulse, ackn);
        xfer(1'b1, Base + 32'h8, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("count_clr_strobe", rd, 32'd1);
`else
        strobe(32'h5);
        xfer(1'b1, Base + 32'h8, 32'h0, 4'hF, 1'b0, 32'h0, rd, ack, pulse, ackn);
        check("count_absent_ack", {31'd0, ack}, 32'd1);
        check("count_absent", rd, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
